// File: rtl/pos_pkg.sv
// Shared POS keypad definitions: key codes, keypad grid bounds and entry FSM states.
// The grid bounds are shared with the cursor controller for its own range checks.
package pos_pkg;

    typedef logic [3:0] key_t;

    localparam key_t KEY_CLR = 4'hA;
    localparam key_t KEY_ENT = 4'hB;

    localparam logic [3:0] GRID_COLS = 4'd3;
    localparam logic [3:0] GRID_ROWS = 4'd4;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        DONE
    } entry_state_t;

endpackage

// File: rtl/pos_key_decode.sv
// Combinational decode of the 3x4 keypad cell under the cursor into a key code.
// Cells outside the grid report valid=0 and the press is dropped by the caller.
module pos_key_decode
    import pos_pkg::*;
(
    input  logic [3:0] cursor_x,
    input  logic [3:0] cursor_y,
    output logic       valid,
    output key_t       key
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        valid = (cursor_x < GRID_COLS) && (cursor_y < GRID_ROWS);
        key   = '0;
        case (cursor_y)
            4'd0: key = cursor_x + 4'd1;
            4'd1: key = cursor_x + 4'd4;
            4'd2: key = cursor_x + 4'd7;
            4'd3: begin
                case (cursor_x)
                    4'd0:    key = KEY_CLR;
                    4'd1:    key = 4'd0;
                    default: key = KEY_ENT;
                endcase
            end
            default: key = '0;
        endcase
    end

endmodule

// File: rtl/pos_key_entry.sv
// POS key entry: turns select-button presses over the keypad into a BCD entry register,
// commits it to amount_bcd on ENT and flags digit overflow or an empty ENT.
module pos_key_entry
    import pos_pkg::*;
#(
    parameter int NDIG = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_sel,
    input  logic [3:0]        cursor_x,
    input  logic [3:0]        cursor_y,
    output logic [4*NDIG-1:0] entry_bcd,
    output logic [3:0]        digit_cnt,
    output logic [4*NDIG-1:0] amount_bcd,
    output logic              amount_valid,
    output logic              key_pulse,
    output key_t              key_code,
    output logic              entry_err
);

    localparam int         W        = 4 * NDIG;
    localparam logic [3:0] NDIG_CNT = 4'(NDIG);

    logic         sel_d;
    logic         press;
    logic         cell_valid;
    key_t         cell_key;
    entry_state_t state, state_nxt;
    logic [W-1:0] entry_nxt, amount_nxt;
    logic [3:0]   cnt_nxt;
    key_t         code_nxt;
    logic         pulse_nxt, err_nxt, commit_nxt, commit_q;

    pos_key_decode u_decode (
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .valid    (cell_valid),
        .key      (cell_key)
    );

    // sel_d resets high so a button already low at the first edge after reset is a press.
    assign press = ~btn_sel & sel_d;

    always_comb begin
        state_nxt  = state;
        entry_nxt  = entry_bcd;
        cnt_nxt    = digit_cnt;
        amount_nxt = amount_bcd;
        code_nxt   = key_code;
        pulse_nxt  = 1'b0;
        err_nxt    = 1'b0;
        commit_nxt = 1'b0;
        if (press && cell_valid) begin
            pulse_nxt = 1'b1;
            code_nxt  = cell_key;
            if (cell_key == KEY_CLR) begin
                entry_nxt = '0;
                cnt_nxt   = '0;
                state_nxt = EMPTY;
            end else if (cell_key == KEY_ENT) begin
                if (state == ENTRY) begin
                    amount_nxt = entry_bcd;
                    entry_nxt  = '0;
                    cnt_nxt    = '0;
                    state_nxt  = DONE;
                    commit_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (digit_cnt == NDIG_CNT) begin
                err_nxt = 1'b1;
            end else if (!(digit_cnt == 4'd0 && cell_key == 4'd0)) begin
                // Leading zeros are accepted as keys but never occupy a digit slot.
                entry_nxt = (entry_bcd << 4) | W'(cell_key);
                cnt_nxt   = digit_cnt + 4'd1;
                state_nxt = ENTRY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // NOTE: every register here is cleared by the async reset; none is a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_d        <= 1'b1;
            entry_bcd    <= '0;
            digit_cnt    <= '0;
            amount_bcd   <= '0;
            key_code     <= '0;
            key_pulse    <= 1'b0;
            entry_err    <= 1'b0;
            commit_q     <= 1'b0;
            amount_valid <= 1'b0;
        end else begin
            sel_d        <= btn_sel;
            entry_bcd    <= entry_nxt;
            digit_cnt    <= cnt_nxt;
            amount_bcd   <= amount_nxt;
            key_code     <= code_nxt;
            key_pulse    <= pulse_nxt;
            entry_err    <= err_nxt;
            commit_q     <= commit_nxt;
            amount_valid <= commit_q;
        end
    end

endmodule

// File: tb/tb_pos_key_entry.sv
// Self-checking bench for pos_key_entry: directed scenarios plus random presses
// compared against a digit-queue model of the keypad entry rules.
module tb_pos_key_entry;
    import pos_pkg::*;

    localparam int NDIG = 6;
    localparam int W    = 4 * NDIG;
    localparam int TW   = 2 * W + 11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_sel = 1'b1;
    logic [3:0]   cursor_x = '0;
    logic [3:0]   cursor_y = '0;
    logic [W-1:0] entry_bcd, amount_bcd;
    logic [3:0]   digit_cnt;
    logic         amount_valid, key_pulse, entry_err;
    key_t         key_code;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: typed digits in order (first typed = most significant).
    int           q[$];
    logic [W-1:0] m_amount = '0;
    key_t         m_code = '0;

    key_t keymap [4][3] = '{'{4'd1, 4'd2, 4'd3},
                            '{4'd4, 4'd5, 4'd6},
                            '{4'd7, 4'd8, 4'd9},
                            '{KEY_CLR, 4'd0, KEY_ENT}};

    pos_key_entry #(.NDIG(NDIG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_sel      (btn_sel),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .entry_bcd    (entry_bcd),
        .digit_cnt    (digit_cnt),
        .amount_bcd   (amount_bcd),
        .amount_valid (amount_valid),
        .key_pulse    (key_pulse),
        .key_code     (key_code),
        .entry_err    (entry_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_entry();
        logic [W-1:0] r = '0;
        for (int i = 0; i < q.size(); i++)
            r[4*(q.size()-1-i) +: 4] = 4'(q[i]);
        return r;
    endfunction

    function automatic logic [TW-1:0] obs_vec();
        return {key_pulse, key_code, entry_bcd, digit_cnt, entry_err, amount_bcd, amount_valid};
    endfunction

    function automatic logic [TW-1:0] exp_vec(input logic p, input logic e, input logic av);
        return {p, m_code, model_entry(), 4'(q.size()), e, m_amount, av};
    endfunction

    task automatic model_reset();
        q.delete();
        m_amount = '0;
        m_code   = '0;
    endtask

    // Apply one press to the model; report expected pulse, error and commit.
    task automatic model_apply(input int x, input int y,
                               output logic p, output logic e, output logic c);
        key_t k;
        p = 1'b0; e = 1'b0; c = 1'b0;
        if (x < 3 && y < 4) begin
            k = keymap[y][x];
            p = 1'b1;
            m_code = k;
            if (k == KEY_CLR) begin
                q.delete();
            end else if (k == KEY_ENT) begin
                if (q.size() > 0) begin
                    m_amount = model_entry();
                    q.delete();
                    c = 1'b1;
                end else begin
                    e = 1'b1;
                end
            end else if (q.size() == NDIG) begin
                e = 1'b1;
            end else if (!(q.size() == 0 && k == 4'd0)) begin
                q.push_back(int'(k));
            end
        end
    endtask

    // One press-and-release over three cycles; cursor wiggles while the button is up.
    task automatic press(input int x, input int y, input string tag);
        logic p, e, c;
        model_apply(x, y, p, e, c);
        cursor_x = 4'(x);
        cursor_y = 4'(y);
        btn_sel  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== exp_vec(p, e, 1'b0)) begin
            n_errors++;
            $display("FAIL %s press(%0d,%0d): got %h want %h (pulse,code,entry,cnt,err,amount,valid)",
                     tag, x, y, obs_vec(), exp_vec(p, e, 1'b0));
        end
        btn_sel  = 1'b1;
        cursor_x = 4'($urandom_range(0, 15));
        cursor_y = 4'($urandom_range(0, 15));
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== exp_vec(1'b0, 1'b0, c)) begin
            n_errors++;
            $display("FAIL %s after(%0d,%0d): got %h want %h (pulse,code,entry,cnt,err,amount,valid)",
                     tag, x, y, obs_vec(), exp_vec(1'b0, 1'b0, c));
        end
        @(negedge clk);
        n_checks++;
        if (amount_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s amount_valid_len: got %b want 0", tag, amount_valid);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_sel = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++;
            $display("FAIL reset_hold: got %h want 0", obs_vec());
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++;
            $display("FAIL reset_idle: got %h want 0", obs_vec());
        end
    endtask

    task automatic test_commit();
        press(0, 0, "commit_1");
        press(1, 0, "commit_2");
        press(2, 3, "commit_ent");
        n_checks++;
        if (amount_bcd !== W'(24'h12) || digit_cnt !== 4'd0) begin
            n_errors++;
            $display("FAIL commit_amount: got amount=%h cnt=%0d want amount=12 cnt=0", amount_bcd, digit_cnt);
        end
    endtask

    task automatic test_leading_zero();
        press(1, 3, "lz_zero");
        press(1, 1, "lz_five");
        press(1, 3, "lz_zero2");
        n_checks++;
        if (entry_bcd !== W'(24'h50)) begin
            n_errors++;
            $display("FAIL lz_entry: got %h want 50", entry_bcd);
        end
        press(0, 3, "lz_clr");
    endtask

    task automatic test_overflow();
        for (int d = 1; d <= 7; d++)
            press((d - 1) % 3, (d - 1) / 3, "ovf_digit");
        n_checks++;
        if (entry_bcd !== W'(24'h123456) || digit_cnt !== 4'd6) begin
            n_errors++;
            $display("FAIL ovf_entry: got entry=%h cnt=%0d want entry=123456 cnt=6", entry_bcd, digit_cnt);
        end
        press(0, 3, "ovf_clr");
        n_checks++;
        if (entry_bcd !== '0 || amount_bcd !== W'(24'h12)) begin
            n_errors++;
            $display("FAIL ovf_clr: got entry=%h amount=%h want entry=0 amount=12", entry_bcd, amount_bcd);
        end
    endtask

    task automatic test_invalid_and_empty_ent();
        press(3, 0, "inv_x");
        press(1, 4, "inv_y");
        press(2, 3, "ent_empty");
        press(2, 2, "after_inv_9");
        press(2, 3, "ent_9");
        press(2, 3, "ent_done");
    endtask

    task automatic test_cursor_motion();
        for (int i = 0; i < 10; i++) begin
            cursor_x = 4'($urandom_range(0, 3));
            cursor_y = 4'($urandom_range(0, 4));
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== exp_vec(1'b0, 1'b0, 1'b0)) begin
                n_errors++;
                $display("FAIL motion_%0d: got %h want %h", i, obs_vec(), exp_vec(1'b0, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_hold();
        logic p, e, c;
        int   pulses = 0;
        model_apply(0, 1, p, e, c);
        cursor_x = 4'd0;
        cursor_y = 4'd1;
        btn_sel  = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (key_pulse === 1'b1) pulses++;
        end
        btn_sel = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL hold_pulses: got %0d want 1", pulses);
        end
        n_checks++;
        if (obs_vec() !== exp_vec(1'b0, 1'b0, 1'b0)) begin
            n_errors++;
            $display("FAIL hold_state: got %h want %h", obs_vec(), exp_vec(1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_entry();
        logic p, e, c;
        press(2, 0, "mid_3");
        press(0, 2, "mid_7");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_async: got %h want 0", obs_vec());
        end
        // Button held low across reset release: the first edge counts as a press.
        cursor_x = 4'd0;
        cursor_y = 4'd0;
        btn_sel  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_apply(0, 0, p, e, c);
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== exp_vec(p, e, 1'b0)) begin
            n_errors++;
            $display("FAIL held_through_reset: got %h want %h", obs_vec(), exp_vec(p, e, 1'b0));
        end
        btn_sel = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++)
            press($urandom_range(0, 3), $urandom_range(0, 4), "rand");
    endtask

    initial begin
        test_reset();
        test_commit();
        test_leading_zero();
        test_overflow();
        test_invalid_and_empty_ent();
        test_cursor_motion();
        test_hold();
        test_random();
        test_reset_mid_entry();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
